vgafetch_ctrl: RTL and testbench
================================

# vgafetch_ctrl

Framebuffer fetch sequencer for the 640x480 bitplane display. It runs in the CPU `clk` domain and walks the framebuffer address range once per frame. It issues single-word read requests to the memory arbiter and buffers the returned words in a small FIFO. It presents the FIFO head to the display as red/green/blue/bright bytes and pops one word per display `rd` pulse.

## Interface
Parameters:
- `ADDR_W`, 30: word-address width of the memory port.
- `FIFO_LOG2`, 4: log2 of FIFO depth in 32-bit words; depth is 16 by default.
- `FRAME_WORDS`, 38400: words fetched per frame (80 words/line x 480 lines).

Ports:
- `clk` in 1: CPU clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: fetch enable; sampled only at frame start.
- `base_addr` in ADDR_W: framebuffer word address; latched at frame start.
- `vga_vsync` in 1: active-low vsync from the display; asynchronous to `clk`.
- `rd` in 1: one-`clk` pulse meaning "word consumed, pop".
- `red_byte`, `green_byte`, `blue_byte`, `bright_byte` out 8 each: FIFO head, equal to `mem_data[7:0]`, `[15:8]`, `[23:16]` and `[31:24]` respectively.
- `mem_req` out 1: read request.
- `mem_addr` out ADDR_W: request word address.
- `mem_ack` in 1: one-cycle acknowledge; `mem_data` is valid in the same cycle.
- `mem_data` in 32: read data.
- `underrun` out 1: sticky flag, set by `rd` while the FIFO is empty.
- `underrun_clr` in 1: clears `underrun`.
- `underrun_cnt` out 16: see Configuration.

## Operation
- `vga_vsync` passes through a 2-flop synchronizer. A falling edge of the synchronized signal is the frame-start event `fs`.
- States:
  - IDLE is the reset state. On `fs` with `enable`=1 → FLUSH. On `fs` with `enable`=0 it stays in IDLE.
  - FLUSH (1 cycle): FIFO emptied; `addr` ← `base_addr`; `words` ← 0 → FETCH.
  - FETCH: `mem_req` is asserted while `count + pend < depth` and `words < FRAME_WORDS`.
    - At most one request is outstanding (`pend` ∈ {0,1}).
    - `mem_addr` holds `addr` stable until `mem_ack`.
    - On `mem_ack`: push `mem_data`, `addr`++, `words`++, drop `mem_req` for at least one cycle.
    - When `words` reaches FRAME_WORDS → DONE.
  - DONE: no requests. On `fs` → FLUSH if `enable`=1, else IDLE.
- `fs` in FETCH with a request pending:
  - `mem_req` stays high until `mem_ack` (the bus protocol forbids withdrawal).
  - The acked data is discarded.
  - After that ack the block goes to FLUSH.
  - This is the only case where `fs` does not act immediately.
- FIFO behaviour:
  - Push and pop in the same cycle leave `count` unchanged.
  - `rd` when empty: no pop, `count` stays 0, `underrun` is set.
  - Push when full cannot occur because of the request gating.
- Output bytes:
  - They are the registered FIFO head and change only on a pop, a push into an empty FIFO, or a flush.
  - When the FIFO is empty, all output bytes are 0.
- Pointers wrap modulo depth. `addr` wraps modulo 2^ADDR_W.
- `underrun_clr` and an underrun in the same cycle: set wins.

## Timing
- Reset values: state IDLE, `mem_req`=0, `mem_addr`=0, all output bytes 0, `underrun`=0, `underrun_cnt`=0, FIFO empty.
- `vga_vsync` falls at cycle 0 → `fs` is decoded at cycle 2 → FLUSH at cycle 3 → `mem_req`=1 at cycle 4 with `mem_addr`=`base_addr`.
- `mem_ack` at cycle N → data appears on the output bytes at N+1 if the FIFO was empty.
- The next `mem_req` can be asserted at the earliest at N+2.
- `rd` at cycle N → the next word appears on the outputs at N+1.

## Configuration
- `VGAFETCH_UNDERRUN_CNT_EN` defined:
  - `underrun_cnt` is a 16-bit saturating counter, incremented on each `rd` while the FIFO is empty.
  - It is cleared by `underrun_clr` and by reset.
  - It saturates at 16'hFFFF.
- Not defined: `underrun_cnt` is constant 0 and no counter logic is built. The `underrun` flag is present in both builds.

## Test plan
- Reset → `mem_req`=0, bytes 0, `underrun`=0. Then vsync fall with `enable`=1 and `base_addr`=0x100 → `mem_req` rises 4 cycles later with `mem_addr`=0x100.
- Memory acks every request and no `rd` is given → exactly 16 words are fetched (0x100..0x10F), then `mem_req` stays 0. One `rd` → exactly one new request, with `mem_addr`=0x110.
- `mem_data`=0x44332211 at first ack → `red_byte`=0x11, `green_byte`=0x22, `blue_byte`=0x33, `bright_byte`=0x44 next cycle.
- `FRAME_WORDS`=8 with continuous `rd` → 8 acks, state DONE, no further `mem_req` until the next vsync fall.
- Vsync fall while `mem_req`=1 and the ack is delayed 5 cycles:
  - `mem_req` holds through the delay.
  - The acked data does not appear on the outputs.
  - The next request is at `base_addr`.
- 3 `rd` pulses on an empty FIFO → `underrun`=1 and `underrun_cnt`=3 (0 without the macro). `underrun_clr` → both read 0.

Source files
------------

// File: rtl/vgafetch_ctrl.sv
// Framebuffer fetch sequencer: walks FRAME_WORDS words per frame into a small FIFO for the display.
// Optional build macro VGAFETCH_UNDERRUN_CNT_EN adds a saturating underrun counter.
module vgafetch_ctrl #(
  parameter int ADDR_W      = 30,
  parameter int FIFO_LOG2   = 4,
  parameter int FRAME_WORDS = 38400
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              vga_vsync,
  input  logic              rd,
  output logic [7:0]        red_byte,
  output logic [7:0]        green_byte,
  output logic [7:0]        blue_byte,
  output logic [7:0]        bright_byte,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_data,
  output logic              underrun,
  input  logic              underrun_clr,
  output logic [15:0]       underrun_cnt
);
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int WW    = $clog2(FRAME_WORDS + 1);
  localparam logic [WW-1:0]        FW_TOT  = WW'(FRAME_WORDS);
  localparam logic [WW-1:0]        FW_LAST = WW'(FRAME_WORDS - 1);
  localparam logic [FIFO_LOG2:0]   CNT_ONE = (FIFO_LOG2 + 1)'(1);

  typedef enum logic [1:0] {IDLE, FLUSH, FETCH, DONE} state_e;
  state_e state_q, state_d;

  logic [2:0]           vs_pipe;
  logic                 fs, abort_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [WW-1:0]        words_q;
  logic [31:0]          fifo_mem [DEPTH];
  logic [FIFO_LOG2-1:0] wp_q, rp_q, rp_nxt;
  logic [FIFO_LOG2:0]   count_q;
  logic [31:0]          head_q;
  logic                 ack_ok, push, pop, flush, empty, full, uflow;

  // [0],[1] synchronize vsync; [2] holds the previous synchronized value for edge detect
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vs_pipe <= 3'b111;
    else        vs_pipe <= {vs_pipe[1:0], vga_vsync};

  assign fs     = vs_pipe[2] & ~vs_pipe[1];
  assign flush  = (state_q == FLUSH);
  assign empty  = (count_q == '0);
  assign full   = count_q[FIFO_LOG2];
  assign ack_ok = (state_q == FETCH) && mem_req && mem_ack;
  // an ack that completes an interrupted frame is dropped
  assign push   = ack_ok && !(abort_q || fs);
  assign pop    = rd && !empty && !flush;
  assign uflow  = rd && empty;
  assign rp_nxt = rp_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (fs && enable) state_d = FLUSH;
      FLUSH: state_d = FETCH;
      FETCH:
        if (ack_ok && (abort_q || fs))      state_d = FLUSH;
        else if (fs && !mem_req)            state_d = enable ? FLUSH : IDLE;
        else if (push && words_q == FW_LAST) state_d = DONE;
      DONE:  if (fs) state_d = enable ? FLUSH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // request cannot be withdrawn, so a frame start mid-request is remembered until the ack
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                                   abort_q <= 1'b0;
    else if (flush || ack_ok)                     abort_q <= 1'b0;
    else if (state_q == FETCH && fs && mem_req)   abort_q <= 1'b1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mem_req <= 1'b0;
    else if (flush) mem_req <= 1'b1;
    else if (state_q == FETCH) begin
      if (mem_req) begin
        if (mem_ack) mem_req <= 1'b0;
      end else if (!fs && !full && words_q < FW_TOT) mem_req <= 1'b1;
    end else mem_req <= 1'b0;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q  <= '0;
      words_q <= '0;
    end else if (flush) begin
      addr_q  <= base_addr;
      words_q <= '0;
    end else if (push) begin
      addr_q  <= addr_q + 1'b1;
      words_q <= words_q + 1'b1;
    end

  always_ff @(posedge clk)
    if (push) fifo_mem[wp_q] <= mem_data;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else if (flush) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_nxt;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end

  // head register: next stored word, the word being written, or zero when the FIFO drains
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)              head_q <= '0;
    else if (flush)          head_q <= '0;
    else if (pop)            head_q <= (count_q == CNT_ONE) ? (push ? mem_data : 32'h0)
                                                            : fifo_mem[rp_nxt];
    else if (push && empty)  head_q <= mem_data;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)            underrun <= 1'b0;
    else if (uflow)        underrun <= 1'b1;
    else if (underrun_clr) underrun <= 1'b0;

`ifdef VGAFETCH_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ucnt_q <= '0;
    else if (uflow) begin
      if (ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 16'd1;
    end else if (underrun_clr) ucnt_q <= '0;
  assign underrun_cnt = ucnt_q;
`else
  assign underrun_cnt = 16'h0;
`endif

  assign mem_addr    = addr_q;
  assign red_byte    = head_q[7:0];
  assign green_byte  = head_q[15:8];
  assign blue_byte   = head_q[23:16];
  assign bright_byte = head_q[31:24];
endmodule

// File: tb/tb_vgafetch_ctrl.sv
// Bench for vgafetch_ctrl: default instance for fill/flow/abort/underrun, FRAME_WORDS=8 instance for frame end.
module tb_vgafetch_ctrl;
  localparam int AW = 30;
`ifdef VGAFETCH_UNDERRUN_CNT_EN
  localparam logic [15:0] EXP_U3 = 16'd3;
`else
  localparam logic [15:0] EXP_U3 = 16'd0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, enable_a, enable_b, vsync_a, vsync_b, rd_a, rd_b, ack_a, ack_b, uclr;
  logic [AW-1:0] base_addr, addr_a, addr_b;
  logic [31:0]   mem_data, head_a, head_b;
  logic [7:0]    r_a, g_a, b_a, br_a, r_b, g_b, b_b, br_b;
  logic          req_a, req_b, und_a, und_b;
  logic [15:0]   ucnt_a, ucnt_b;

  assign head_a = {br_a, b_a, g_a, r_a};
  assign head_b = {br_b, b_b, g_b, r_b};

  vgafetch_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable_a), .base_addr(base_addr), .vga_vsync(vsync_a),
    .rd(rd_a), .red_byte(r_a), .green_byte(g_a), .blue_byte(b_a), .bright_byte(br_a),
    .mem_req(req_a), .mem_addr(addr_a), .mem_ack(ack_a), .mem_data(mem_data),
    .underrun(und_a), .underrun_clr(uclr), .underrun_cnt(ucnt_a));

  vgafetch_ctrl #(.FRAME_WORDS(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable_b), .base_addr(base_addr), .vga_vsync(vsync_b),
    .rd(rd_b), .red_byte(r_b), .green_byte(g_b), .blue_byte(b_b), .bright_byte(br_b),
    .mem_req(req_b), .mem_addr(addr_b), .mem_ack(ack_b), .mem_data(mem_data),
    .underrun(und_b), .underrun_clr(uclr), .underrun_cnt(ucnt_b));

  typedef struct {
    logic [31:0] data;
    logic [7:0]  r, g, b, br;
  } vec_t;
  vec_t vecs [4];

  logic [31:0] exp_q [$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dat(input logic [AW-1:0] a);
    logic [7:0] o;
    o = a[7:0];
    return {8'h44 + o, 8'h33 + o, 8'h22 + o, 8'h11 + o};
  endfunction

  task automatic wait_req_a();
    int i;
    i = 0;
    while (!req_a && i < 20) begin tick(); i++; end
    chk("req_a_wait", {31'b0, req_a}, 32'd1);
  endtask

  // head must equal the scoreboard front; after the pop it must show the next entry (or 0)
  task automatic rd_pop_a(input string nm);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q[0] : 32'h0;
    chk({nm, "_head"}, head_a, e);
    rd_a = 1'b1; tick(); rd_a = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    e = (exp_q.size() > 0) ? exp_q[0] : 32'h0;
    chk({nm, "_next"}, head_a, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ea, eb;
    bit seen, acked;
    int n;

    vecs[0] = '{data: 32'hDEADBEEF, r: 8'hEF, g: 8'hBE, b: 8'hAD, br: 8'hDE};
    vecs[1] = '{data: 32'h80FF0180, r: 8'h80, g: 8'h01, b: 8'hFF, br: 8'h80};
    vecs[2] = '{data: 32'hFFFFFFFF, r: 8'hFF, g: 8'hFF, b: 8'hFF, br: 8'hFF};
    vecs[3] = '{data: 32'h01234567, r: 8'h67, g: 8'h45, b: 8'h23, br: 8'h01};

    rst_n = 0; enable_a = 0; enable_b = 0; vsync_a = 1; vsync_b = 1;
    rd_a = 0; rd_b = 0; ack_a = 0; ack_b = 0; uclr = 0; base_addr = '0; mem_data = '0;
    repeat (3) tick();
    chk("rst_req_a", {31'b0, req_a}, 0);
    chk("rst_addr_a", {2'b0, addr_a}, 0);
    chk("rst_head_a", head_a, 0);
    chk("rst_und_a", {31'b0, und_a}, 0);
    chk("rst_ucnt_a", {16'b0, ucnt_a}, 0);
    chk("rst_req_b", {31'b0, req_b}, 0);
    rst_n = 1;
    repeat (2) tick();

    // frame start with enable low: stays idle
    base_addr = 30'h100;
    vsync_a = 0; seen = 0;
    repeat (10) begin tick(); seen |= req_a; end
    chk("idle_no_req", {31'b0, seen}, 0);
    vsync_a = 1;
    repeat (4) tick();

    // underrun on an empty FIFO
    repeat (3) begin rd_a = 1; tick(); rd_a = 0; tick(); end
    chk("und_set", {31'b0, und_a}, 1);
    chk("und_cnt", {16'b0, ucnt_a}, {16'b0, EXP_U3});
    chk("und_head", head_a, 0);
    uclr = 1; tick(); uclr = 0;
    chk("und_clr", {31'b0, und_a}, 0);
    chk("ucnt_clr", {16'b0, ucnt_a}, 0);
    rd_a = 1; uclr = 1; tick(); rd_a = 0; uclr = 0;
    chk("und_set_wins", {31'b0, und_a}, 1);
    uclr = 1; tick(); uclr = 0;
    chk("und_clr2", {31'b0, und_a}, 0);
    chk("ucnt_clr2", {16'b0, ucnt_a}, 0);

    // frame start latency: vsync fall at cycle 0, request at cycle 4
    enable_a = 1; vsync_a = 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("fs_lat_%0d", k), {31'b0, req_a}, 0);
    end
    tick();
    chk("fs_req", {31'b0, req_a}, 1);
    chk("fs_addr", {2'b0, addr_a}, 32'h100);
    vsync_a = 1;

    // fill the FIFO with no reads
    ea = 30'h100;
    for (int i = 0; i < 16; i++) begin
      wait_req_a();
      chk("fill_addr", {2'b0, addr_a}, {2'b0, ea});
      mem_data = dat(ea); ack_a = 1; tick(); ack_a = 0;
      exp_q.push_back(dat(ea));
      chk("fill_gap", {31'b0, req_a}, 0);
      chk("fill_head", head_a, exp_q[0]);
      if (i == 0) begin
        chk("byte_red", {24'b0, r_a}, 32'h11);
        chk("byte_green", {24'b0, g_a}, 32'h22);
        chk("byte_blue", {24'b0, b_a}, 32'h33);
        chk("byte_bright", {24'b0, br_a}, 32'h44);
      end
      ea++;
    end
    seen = 0;
    repeat (10) begin tick(); seen |= req_a; end
    chk("full_no_req", {31'b0, seen}, 0);

    rd_pop_a("pop1");
    wait_req_a();
    chk("refill_addr", {2'b0, addr_a}, 32'h110);
    mem_data = dat(ea); ack_a = 1; tick(); ack_a = 0;
    exp_q.push_back(dat(ea)); ea++;
    seen = 0;
    repeat (8) begin tick(); seen |= req_a; end
    chk("one_req_only", {31'b0, seen}, 0);

    while (exp_q.size() > 0) rd_pop_a("drain");

    // table vectors: byte mapping, N+1 data, N+2 next request
    for (int i = 0; i < 4; i++) begin
      wait_req_a();
      chk("vec_addr", {2'b0, addr_a}, {2'b0, ea});
      mem_data = vecs[i].data; ack_a = 1; tick(); ack_a = 0;
      exp_q.push_back(vecs[i].data);
      chk($sformatf("vec%0d_bytes", i), head_a, {vecs[i].br, vecs[i].b, vecs[i].g, vecs[i].r});
      chk("vec_gap", {31'b0, req_a}, 0);
      tick();
      chk("vec_req_n2", {31'b0, req_a}, 1);
      ea++;
      rd_pop_a("vec_pop");
    end

    // push and pop in the same cycle with one word held
    wait_req_a();
    mem_data = dat(ea); ack_a = 1; tick(); ack_a = 0;
    exp_q.push_back(dat(ea)); ea++;
    wait_req_a();
    chk("pp_addr", {2'b0, addr_a}, {2'b0, ea});
    mem_data = dat(ea); ack_a = 1; rd_a = 1; tick(); ack_a = 0; rd_a = 0;
    void'(exp_q.pop_front());
    exp_q.push_back(dat(ea)); ea++;
    chk("pushpop_head", head_a, exp_q[0]);
    rd_pop_a("pushpop_drain");

    // vsync fall with a request outstanding and a late ack
    base_addr = 30'h200;
    wait_req_a();
    chk("abort_addr0", {2'b0, addr_a}, {2'b0, ea});
    vsync_a = 0; seen = 0;
    repeat (8) begin tick(); if (!req_a) seen = 1; end
    chk("abort_hold", {31'b0, seen}, 0);
    chk("abort_addr_hold", {2'b0, addr_a}, {2'b0, ea});
    vsync_a = 1;
    mem_data = 32'hBAD0BAD0; ack_a = 1; tick(); ack_a = 0;
    chk("abort_gap", {31'b0, req_a}, 0);
    chk("abort_head", head_a, 0);
    wait_req_a();
    chk("abort_new_addr", {2'b0, addr_a}, 32'h200);
    chk("abort_head2", head_a, 0);

    // short frame on the FRAME_WORDS=8 instance with continuous reads
    base_addr = 30'h300; enable_b = 1; vsync_b = 0; rd_b = 1;
    n = 0; eb = 30'h300;
    for (int i = 0; i < 80; i++) begin
      if (i == 6) vsync_b = 1;
      ack_b = 0; acked = 0;
      if (req_b) begin
        chk("b_addr", {2'b0, addr_b}, {2'b0, eb});
        mem_data = dat(eb); ack_b = 1; acked = 1;
      end
      tick();
      if (acked) begin
        chk("b_bytes", head_b, dat(eb));
        eb++; n++;
      end
    end
    ack_b = 0; rd_b = 0;
    chk("b_ack_count", n, 8);
    chk("b_done_req", {31'b0, req_b}, 0);

    enable_b = 0; vsync_b = 0; seen = 0;
    repeat (10) begin tick(); seen |= req_b; end
    chk("b_done_to_idle", {31'b0, seen}, 0);
    vsync_b = 1;
    repeat (4) tick();
    enable_b = 1; vsync_b = 0;
    n = 0;
    while (!req_b && n < 20) begin tick(); n++; end
    chk("b_restart_req", {31'b0, req_b}, 1);
    chk("b_restart_addr", {2'b0, addr_b}, 32'h300);
    vsync_b = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
